branch_predict_global: RTL

BRANCH_PREDICT_GLOBAL -- requirements
Module: branch_predict_global

---
 rtl/branch_predict_global.sv | 101 ++++++++++
 1 files changed

// File: rtl/branch_predict_global.sv
// Gshare global branch predictor: PHT of 2-bit counters indexed by pc XOR GHR,
// speculative GHR shift in D and repair from the M-stage snapshot on mispredict.
module branch_predict_global #(
  parameter int PHT_DEPTH = 10,
  parameter int PC_LSB    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flushD,
  input  logic        flushE,
  input  logic        flushM,
  input  logic        stallD,
  input  logic [31:0] pcF,
  input  logic [31:0] pcM,
  input  logic        branchD,
  input  logic        branchM,
  input  logic        actual_takeM,
  output logic        pred_takeD,
  output logic        global_errorM
);

  localparam int PhtSize = 2 ** PHT_DEPTH;

  logic [1:0]           pht [PhtSize];
  logic [PHT_DEPTH-1:0] ghr;
  logic [PHT_DEPTH-1:0] indexF, indexD, indexE, indexM;
  logic [PHT_DEPTH-1:0] ghrD, ghrE, ghrM;
  logic                 predF, predD, predE, predM;
  logic                 shiftD;

  // The M-stage index travels with the instruction, so pcM and the pcF bits
  // outside the index field are not needed.
  logic unusedPcBits;
  assign unusedPcBits = ^{pcM, pcF[31:PC_LSB+PHT_DEPTH], pcF[PC_LSB-1:0]};

  assign indexF        = pcF[PC_LSB+PHT_DEPTH-1:PC_LSB] ^ ghr;
  assign predF         = pht[indexF][1];
  assign pred_takeD    = predD;
  assign global_errorM = ~rst & branchM & (predM != actual_takeM);
  assign shiftD        = branchD & ~stallD & ~flushD;

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr <= '0;
    end else if (global_errorM) begin
      ghr <= {ghrM[PHT_DEPTH-2:0], actual_takeM};
    end else if (shiftD) begin
      ghr <= {ghr[PHT_DEPTH-2:0], pred_takeD};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PhtSize; i++) pht[i] <= 2'b01;
    end else if (branchM) begin
      if (actual_takeM && pht[indexM] != 2'b11) begin
        pht[indexM] <= pht[indexM] + 2'd1;
      end else if (!actual_takeM && pht[indexM] != 2'b00) begin
        pht[indexM] <= pht[indexM] - 2'd1;
      end
    end
  end

  // Pipeline carry of {pred, index, GHR snapshot}; flush beats stall.
  always_ff @(posedge clk) begin
    if (rst || flushD) begin
      predD  <= 1'b0;
      indexD <= '0;
      ghrD   <= '0;
    end else if (!stallD) begin
      predD  <= predF;
      indexD <= indexF;
      ghrD   <= ghr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flushE) begin
      predE  <= 1'b0;
      indexE <= '0;
      ghrE   <= '0;
    end else begin
      predE  <= predD;
      indexE <= indexD;
      ghrE   <= ghrD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flushM) begin
      predM  <= 1'b0;
      indexM <= '0;
      ghrM   <= '0;
    end else begin
      predM  <= predE;
      indexM <= indexE;
      ghrM   <= ghrE;
    end
  end

endmodule
